// File: rtl/snake_disp_pkg.sv
// ---------------------------------------------------------------------------
// snake_disp_pkg
// Shared definitions for the LED matrix display path.
//   ROWS / COLS  : matrix geometry (16 x 16)
//   ROW_W        : width of a row index
//   scan_state_t : row-scan phase (BLANK = all off, DRIVE = row lit)
//   row_word_t   : one row of column bits, bit c lights column c
//   row_select() : one-hot row-select word for a row index
// ---------------------------------------------------------------------------
package snake_disp_pkg;

    localparam int ROWS  = 16;
    localparam int COLS  = 16;
    localparam int ROW_W = $clog2(ROWS);

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    typedef logic [COLS-1:0]  row_word_t;
    typedef logic [ROW_W-1:0] row_idx_t;

    function automatic row_word_t row_select(input row_idx_t row);
        return row_word_t'(1) << row;
    endfunction

endpackage

// File: rtl/frame_bank.sv
// ---------------------------------------------------------------------------
// frame_bank
// Two-bank (front/back) row store for the LED matrix.
//   clk, rst_n  : clock; synchronous active-low clear of both banks
//   we          : write enable for the back bank
//   front_sel   : which bank is currently displayed (0 or 1)
//   wr_row      : back-bank row to write
//   wr_data     : row word to write
//   rd_row      : front-bank row to read
//   rd_data     : combinational read of front[rd_row]
// Writes always target the bank that is NOT front_sel, so the displayed
// bank can never be modified while it is on screen.
// ---------------------------------------------------------------------------
module frame_bank
    import snake_disp_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      we,
    input  logic      front_sel,
    input  row_idx_t  wr_row,
    input  row_word_t wr_data,
    input  row_idx_t  rd_row,
    output row_word_t rd_data
);

    localparam int WORDS = 2 * ROWS;

    logic [ROW_W:0]   wr_addr;
    logic [ROW_W:0]   rd_addr;
    logic [WORDS-1:0] wr_hit;
    row_word_t        mem [WORDS];

    assign wr_addr = {~front_sel, wr_row};
    assign rd_addr = {front_sel, rd_row};

    // Per-word write decode.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_hit
            assign wr_hit[gi] = we && (wr_addr == (ROW_W + 1)'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WORDS; i++) begin
                if (wr_hit[i]) begin
                    mem[i] <= wr_data;
                end
            end
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/led_scan_sched.sv
// ---------------------------------------------------------------------------
// led_scan_sched
// Row-scan scheduler with a double-buffered 16x16 frame store.
//   clk, rst_n     : clock; synchronous active-low reset
//   wr_valid/ready : row-word write handshake into the back buffer
//   wr_row/wr_data : back-buffer row index and row word
//   commit         : request a front/back swap at the next frame boundary
//   commit_pending : swap queued; back buffer frozen (wr_ready low)
//   swapped        : pulse on the first cycle of a newly swapped frame
//   frame_start    : pulse on the first cycle of row 0 (its blank phase)
//   row_idx        : row being scanned, including its blank phase
//   LED_R / LED_C  : one-hot row select / column data, zero while blanking
// Each row is BLANK_TICKS cycles dark followed by ROW_TICKS cycles lit.
//
// The scan FSM runs one cycle ahead of the registered outputs: the outputs
// in a cycle are a decode of the FSM position of the previous cycle. This
// lets frame_start appear in the very first cycle after reset while the
// reset cycle itself shows all-zero outputs. The swap decision is taken on
// the FSM's frame-first position so that the front_sel toggle, the pending
// clear (wr_ready rising) and the swapped/frame_start pulses all become
// visible in the same cycle, right after the last lit cycle of row 15.
// ---------------------------------------------------------------------------
module led_scan_sched
    import snake_disp_pkg::*;
#(
    parameter int ROW_TICKS   = 1000,
    parameter int BLANK_TICKS = 8
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    input  logic [3:0]  wr_row,
    input  logic [15:0] wr_data,
    output logic        wr_ready,
    input  logic        commit,
    output logic        commit_pending,
    output logic        swapped,
    output logic        frame_start,
    output logic [3:0]  row_idx,
    output logic [15:0] LED_R,
    output logic [15:0] LED_C
);

    localparam int MAX_TICKS = (ROW_TICKS > BLANK_TICKS) ? ROW_TICKS : BLANK_TICKS;
    localparam int TICK_W    = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [TICK_W-1:0] ROW_LAST   = TICK_W'(ROW_TICKS - 1);
    localparam logic [TICK_W-1:0] BLANK_LAST = (BLANK_TICKS > 0) ? TICK_W'(BLANK_TICKS - 1) : '0;

    // With blanking disabled a row begins directly in DRIVE.
    localparam scan_state_t ROW_START = (BLANK_TICKS > 0) ? BLANK : DRIVE;

    scan_state_t       state_reg, state_next;
    row_idx_t          row_reg, row_next;
    logic [TICK_W-1:0] tick_reg, tick_next;
    logic              front_sel_reg;
    logic              commit_pending_reg;

    row_word_t         led_r_reg;
    row_word_t         led_c_reg;
    row_idx_t          row_idx_reg;
    logic              frame_start_reg;
    logic              swapped_reg;

    row_word_t         rd_data;
    logic              frame_first;
    logic              do_swap;
    logic              wr_en;

    // FSM sits on the first tick of row 0: the next outputs start a frame.
    assign frame_first = (row_reg == '0) && (tick_reg == '0) && (state_reg == ROW_START);
    assign do_swap     = frame_first && commit_pending_reg;
    assign wr_en       = wr_valid && !commit_pending_reg;

    frame_bank u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (wr_en),
        .front_sel (front_sel_reg),
        .wr_row    (wr_row),
        .wr_data   (wr_data),
        .rd_row    (row_reg),
        .rd_data   (rd_data)
    );

    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        tick_next  = tick_reg + 1'b1;
        case (state_reg)
            BLANK: begin
                if (tick_reg == BLANK_LAST) begin
                    state_next = DRIVE;
                    tick_next  = '0;
                end
            end
            DRIVE: begin
                if (tick_reg == ROW_LAST) begin
                    state_next = ROW_START;
                    tick_next  = '0;
                    row_next   = row_reg + 1'b1;
                end
            end
            default: begin
                state_next = ROW_START;
                tick_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg          <= ROW_START;
            row_reg            <= '0;
            tick_reg           <= '0;
            front_sel_reg      <= 1'b0;
            commit_pending_reg <= 1'b0;
            led_r_reg          <= '0;
            led_c_reg          <= '0;
            row_idx_reg        <= '0;
            frame_start_reg    <= 1'b0;
            swapped_reg        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            row_reg       <= row_next;
            tick_reg      <= tick_next;
            front_sel_reg <= front_sel_reg ^ do_swap;

            // A commit seen while already pending (including the swap
            // cycle itself) is absorbed.
            if (do_swap) begin
                commit_pending_reg <= 1'b0;
            end else if (commit) begin
                commit_pending_reg <= 1'b1;
            end

            led_r_reg       <= (state_reg == DRIVE) ? row_select(row_reg) : '0;
            led_c_reg       <= (state_reg == DRIVE) ? rd_data : '0;
            row_idx_reg     <= row_reg;
            frame_start_reg <= frame_first;
            swapped_reg     <= do_swap;
        end
    end

    assign wr_ready       = !commit_pending_reg;
    assign commit_pending = commit_pending_reg;
    assign swapped        = swapped_reg;
    assign frame_start    = frame_start_reg;
    assign row_idx        = row_idx_reg;
    assign LED_R          = led_r_reg;
    assign LED_C          = led_c_reg;

endmodule

// File: tb/tb_led_scan_sched.sv
// ---------------------------------------------------------------------------
// tb_led_scan_sched
// Scoreboard bench for led_scan_sched with ROW_TICKS = 4, BLANK_TICKS = 2
// (row period 6, frame period 96). The reference model tracks the cycle
// count since reset and derives the frame position arithmetically; it keeps
// the two frame buffers and the commit flag as plain arrays/bits. Expected
// outputs are queued per clock edge and checked by an independent monitor
// on the falling edge.
// ---------------------------------------------------------------------------
module tb_led_scan_sched;

    localparam int RT = 4;
    localparam int BT = 2;
    localparam int RP = RT + BT;
    localparam int FP = 16 * RP;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [3:0]  wr_row = 4'h0;
    logic [15:0] wr_data = 16'h0;
    logic        commit = 1'b0;
    logic        wr_ready;
    logic        commit_pending;
    logic        swapped;
    logic        frame_start;
    logic [3:0]  row_idx;
    logic [15:0] LED_R;
    logic [15:0] LED_C;

    led_scan_sched #(
        .ROW_TICKS   (RT),
        .BLANK_TICKS (BT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_valid       (wr_valid),
        .wr_row         (wr_row),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .commit         (commit),
        .commit_pending (commit_pending),
        .swapped        (swapped),
        .frame_start    (frame_start),
        .row_idx        (row_idx),
        .LED_R          (LED_R),
        .LED_C          (LED_C)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] r;
        logic [15:0] c;
        logic [3:0]  row;
        logic        fs;
        logic        sw;
        logic        pend;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk = 0;
    int          n_fail = 0;

    // Reference state
    logic [15:0] mbank [2][16];
    bit          mfront = 1'b0;
    bit          mpend = 1'b0;
    int          t = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (time %0t)", nm, act, req, $time);
        end
    endtask

    // One clock edge: DUT samples the current inputs, the model advances
    // with the same inputs and queues what the outputs must be afterwards.
    task automatic cycle();
        exp_t e;
        int   p;
        int   row;
        bit   prev;
        bit   drive;
        @(posedge clk);
        if (!rst_n) begin
            t = 0;
            mfront = 1'b0;
            mpend = 1'b0;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < 16; r++)
                    mbank[b][r] = 16'h0;
            e.r = 16'h0; e.c = 16'h0; e.row = 4'h0;
            e.fs = 1'b0; e.sw = 1'b0; e.pend = 1'b0;
            $display("reset applied");
        end else begin
            t++;
            p = (t - 1) % FP;
            row = p / RP;
            drive = (p % RP) >= BT;
            prev = mpend;
            e.sw = (p == 0) && prev;
            if (wr_valid && !prev) begin
                mbank[mfront ? 0 : 1][wr_row] = wr_data;
                $display("write row %0d = %h", wr_row, wr_data);
            end
            if (e.sw) begin
                mpend = 1'b0;
                mfront = !mfront;
                $display("swap, front bank now %0d", mfront);
            end else if (commit && !prev) begin
                mpend = 1'b1;
                $display("commit accepted at frame position %0d", (p + FP - 1) % FP);
            end
            e.r = drive ? (16'h1 << row) : 16'h0;
            e.c = drive ? mbank[mfront ? 1 : 0][row] : 16'h0;
            e.row = 4'(row);
            e.fs = (p == 0);
            e.pend = mpend;
        end
        sb_q.push_back(e);
        #1;
    endtask

    // Advance until the visible output cycle sits at frame position target.
    task automatic wait_pos(input int target);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 3 * FP; k++) begin
            if (t > 0 && ((t - 1) % FP) == target) begin
                hit = 1'b1;
                break;
            end
            cycle();
        end
        if (!hit) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_pos: frame position %0d not reached", target);
        end
    endtask

    // Monitor: outputs are presented every cycle, compare on falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("LED_R", LED_R, e.r);
            chk("LED_C", LED_C, e.c);
            chk("row_idx", {12'h0, row_idx}, {12'h0, e.row});
            chk("frame_start", {15'h0, frame_start}, {15'h0, e.fs});
            chk("swapped", {15'h0, swapped}, {15'h0, e.sw});
            chk("commit_pending", {15'h0, commit_pending}, {15'h0, e.pend});
            chk("wr_ready", {15'h0, wr_ready}, {15'h0, !e.pend});
        end
    end

    initial begin
        bit stuck;

        // Reset scan
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        repeat (110) cycle();

        // Load and swap, with a blocked write held through the pending window
        wr_valid = 1'b1; wr_row = 4'd3; wr_data = 16'hA5A5;
        cycle();
        wr_valid = 1'b0;
        wait_pos(40);
        commit = 1'b1;
        cycle();
        commit = 1'b0;
        wr_valid = 1'b1; wr_row = 4'd5; wr_data = 16'h1234;
        stuck = 1'b1;
        for (int k = 0; k < 3 * FP; k++) begin
            if (!mpend) begin
                stuck = 1'b0;
                break;
            end
            cycle();
        end
        if (stuck) begin
            n_chk++;
            n_fail++;
            $display("FAIL swap_wait: commit still pending after %0d cycles", 3 * FP);
        end
        cycle();
        wr_valid = 1'b0;
        repeat (110) cycle();

        // Late commit in the last lit cycle of row 15
        wait_pos(FP - 1);
        commit = 1'b1;
        cycle();
        commit = 1'b0;
        repeat (2 * FP + 10) cycle();

        // Same-cycle write and commit
        wr_valid = 1'b1; wr_row = 4'd0; wr_data = 16'hFFFF; commit = 1'b1;
        cycle();
        wr_valid = 1'b0; commit = 1'b0;
        repeat (2 * FP + 10) cycle();

        // Mid-frame reset during row 7 with a commit pending
        wait_pos(10);
        commit = 1'b1;
        cycle();
        commit = 1'b0;
        wait_pos(7 * RP);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        repeat (40) cycle();

        // Randomized traffic
        for (int k = 0; k < 2000; k++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_row   = 4'($urandom_range(0, 15));
            wr_data  = 16'($urandom);
            commit   = ($urandom_range(0, 39) == 0);
            rst_n    = ($urandom_range(0, 699) != 0);
            cycle();
        end
        wr_valid = 1'b0; commit = 1'b0; rst_n = 1'b1;
        cycle();
        @(negedge clk);
        #1;
        n_chk++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
